adder_share_arb: RTL and testbench

ADDER_SHARE_ARB -- requirements
Module: adder_share_arb

---
 rtl/adder_share_arb_pkg.sv | 12 +
 rtl/adder.sv | 45 ++++
 rtl/adder_share_arb.sv | 129 ++++++++++++
 tb/tb_adder_share_arb.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_arb_pkg.sv
// Shared constants for the adder-sharing arbiter:
// requester count, operand width, ID width and FSM state encoding.
package adder_share_arb_pkg;

    localparam int P_NREQ  = 4;
    localparam int P_WIDTH = 20;
    localparam int P_IDW   = 2;

    localparam logic ST_ARB  = 1'b0;
    localparam logic ST_LOCK = 1'b1;

endpackage

// File: rtl/adder.sv
// Kogge-Stone prefix adder, purely combinational.
// Ports: a, b (WIDTH) operands; cin carry-in; sum (WIDTH); cout carry-out.
module adder #(
    parameter int WIDTH = 20
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LV = $clog2(WIDTH);

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_pp;
    logic [WIDTH-1:0] w_gn;
    logic [WIDTH-1:0] w_pn;

    assign w_p = a ^ b;

    // cin is folded into bit 0's generate, so the final group
    // generate at bit i is the carry out of bit i.
    always_comb begin
        w_g  = (a & b) | {{(WIDTH-1){1'b0}}, w_p[0] & cin};
        w_pp = w_p;
        w_gn = '0;
        w_pn = '0;
        for (int l = 0; l < LV; l++) begin
            w_gn = w_g;
            w_pn = w_pp;
            for (int i = (1 << l); i < WIDTH; i++) begin
                w_gn[i] = w_g[i] | (w_pp[i] & w_g[i-(1<<l)]);
                w_pn[i] = w_pp[i] & w_pp[i-(1<<l)];
            end
            w_g  = w_gn;
            w_pp = w_pn;
        end
    end

    assign sum  = w_p ^ {w_g[WIDTH-2:0], cin};
    assign cout = w_g[WIDTH-1];

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one adder among NREQ requesters, with
// multi-beat carry chaining (LOCK) and a 1-deep registered result slot.
// Ports: clk, rst_n (sync, active-low); req_valid/ready/a/b/cin/last
// per requester (operands sliced by WIDTH); res_valid/ready/sum/cout/
// id/last registered result with valid/ready handshake.
module adder_share_arb
    import adder_share_arb_pkg::*;
#(
    parameter int NREQ  = P_NREQ,
    parameter int WIDTH = P_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    input  logic [NREQ-1:0]       req_last,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_sum,
    output logic                  res_cout,
    output logic [P_IDW-1:0]      res_id,
    output logic                  res_last
);

    logic             r_state;
    logic [P_IDW-1:0] r_ptr;
    logic [P_IDW-1:0] r_lock_id;
    logic             r_chain_c;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_sum;
    logic             r_res_cout;
    logic [P_IDW-1:0] r_res_id;
    logic             r_res_last;

    logic             w_slot_free;
    logic             w_found;
    logic [P_IDW-1:0] w_win;
    logic [P_IDW-1:0] w_idx;
    logic             w_acc;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    assign w_slot_free = !r_res_valid || res_ready;

    // ARB: rotating search from r_ptr. LOCK: only the chain owner.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        if (r_state == ST_LOCK) begin
            w_win   = r_lock_id;
            w_found = req_valid[r_lock_id];
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                w_idx = r_ptr + P_IDW'(k);
                if (!w_found && req_valid[w_idx]) begin
                    w_found = 1'b1;
                    w_win   = w_idx;
                end
            end
        end
    end

    assign w_acc = rst_n && w_slot_free && w_found;

    always_comb begin
        req_ready = '0;
        if (w_acc) begin
            req_ready[w_win] = 1'b1;
        end
    end

    assign w_a   = req_a[w_win*WIDTH +: WIDTH];
    assign w_b   = req_b[w_win*WIDTH +: WIDTH];
    assign w_cin = (r_state == ST_LOCK) ? r_chain_c : req_cin[w_win];

    adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (w_a),
        .b    (w_b),
        .cin  (w_cin),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_ARB;
            r_ptr       <= '0;
            r_lock_id   <= '0;
            r_chain_c   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_cout  <= 1'b0;
            r_res_id    <= '0;
            r_res_last  <= 1'b0;
        end else if (w_acc) begin
            r_res_valid <= 1'b1;
            r_res_sum   <= w_sum;
            r_res_cout  <= w_cout;
            r_res_id    <= w_win;
            r_res_last  <= req_last[w_win];
            if (req_last[w_win]) begin
                r_state <= ST_ARB;
                r_ptr   <= w_win + 1'b1;
            end else begin
                r_state   <= ST_LOCK;
                r_lock_id <= w_win;
                r_chain_c <= w_cout;
            end
        end else if (w_slot_free) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign res_cout  = r_res_cout;
    assign res_id    = r_res_id;
    assign res_last  = r_res_last;

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_adder_share_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [79:0] req_a = '0;
    logic [79:0] req_b = '0;
    logic [3:0]  req_cin = '0;
    logic [3:0]  req_last = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [19:0] res_sum;
    logic        res_cout;
    logic [1:0]  res_id;
    logic        res_last;

    int vec = 0;
    int bad = 0;

    int          m_ptr  = 0;
    bit          m_lock = 0;
    int          m_lid  = 0;
    bit          m_cc   = 0;
    bit          m_rv   = 0;
    logic [19:0] m_sum  = '0;
    bit          m_cout = 0;
    int          m_id   = 0;
    bit          m_last = 0;

    always #5 clk = ~clk;

    adder_share_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_last  (req_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id),
        .res_last  (res_last)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_beat(input int i, input logic [19:0] a,
                            input logic [19:0] b, input logic c,
                            input logic l);
        req_a[i*20 +: 20] = a;
        req_b[i*20 +: 20] = b;
        req_cin[i]  = c;
        req_last[i] = l;
    endtask

    // Called just after a negedge with inputs driven; checks outputs
    // against the model, then advances the model across the posedge.
    task automatic cycle();
        int          w;
        bit          free;
        bit          acc;
        bit          c;
        logic [20:0] s;
        logic [3:0]  er;
        #1;
        free = !m_rv || res_ready;
        w = -1;
        s = '0;
        if (m_lock) begin
            if (req_valid[m_lid]) w = m_lid;
        end else begin
            for (int k = 0; k < 4; k++)
                if (w < 0 && req_valid[(m_ptr+k)%4]) w = (m_ptr + k) % 4;
        end
        acc = rst_n && free && (w >= 0);
        er = acc ? 4'(1 << w) : 4'b0;
        chk("ready", 32'(req_ready), 32'(er));
        chk("rvalid", 32'(res_valid), 32'(m_rv));
        chk("sum", 32'(res_sum), 32'(m_sum));
        chk("cout", 32'(res_cout), 32'(m_cout));
        chk("id", 32'(res_id), 32'(m_id));
        chk("last", 32'(res_last), 32'(m_last));
        if (acc) begin
            c = m_lock ? m_cc : req_cin[w];
            s = {1'b0, req_a[w*20 +: 20]} + {1'b0, req_b[w*20 +: 20]}
              + 21'(c);
        end
        @(posedge clk);
        if (!rst_n) begin
            m_ptr = 0; m_lock = 0; m_lid = 0; m_cc = 0; m_rv = 0;
            m_sum = '0; m_cout = 0; m_id = 0; m_last = 0;
        end else if (acc) begin
            m_rv   = 1;
            m_sum  = s[19:0];
            m_cout = s[20];
            m_id   = w;
            m_last = req_last[w];
            if (req_last[w]) begin
                m_lock = 0;
                m_ptr  = (w + 1) % 4;
            end else begin
                m_lock = 1;
                m_lid  = w;
                m_cc   = s[20];
            end
        end else if (free) begin
            m_rv = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 4'hF;
        cycle();
        rst_n = 1'b1;
        req_valid = '0;

        set_beat(2, 20'h7FFFF, 20'h00001, 1'b0, 1'b1);
        req_valid = 4'b0100;
        cycle();
        req_valid = '0;
        chk("t38_sum", 32'(res_sum), 32'h80000);
        chk("t38_cout", 32'(res_cout), 32'h0);
        chk("t38_id", 32'(res_id), 32'h2);
        req_valid = 4'hF;
        req_last  = 4'hF;
        #1 chk("t38_ptr", 32'(req_ready), 32'b1000);
        cycle();

        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 chk("t39_rr", 32'(req_ready), 32'(1 << (k % 4)));
            cycle();
        end

        req_valid = 4'b0011;
        set_beat(1, 20'hFFFFF, 20'h00001, 1'b0, 1'b0);
        set_beat(0, 20'h12345, 20'h11111, 1'b1, 1'b1);
        cycle();
        chk("t40_s0", 32'(res_sum), 32'h0);
        chk("t40_c0", 32'(res_cout), 32'h1);
        chk("t40_i0", 32'(res_id), 32'h1);
        req_valid = 4'b0001;
        cycle();
        req_valid = 4'b0011;
        set_beat(1, 20'h0, 20'h0, 1'b1, 1'b1);
        #1 chk("t40_lock", 32'(req_ready), 32'b0010);
        cycle();
        chk("t40_s1", 32'(res_sum), 32'h1);
        chk("t40_c1", 32'(res_cout), 32'h0);
        chk("t40_i1", 32'(res_id), 32'h1);

        res_ready = 1'b0;
        req_valid = 4'hF;
        req_last  = 4'hF;
        repeat (3) begin
            cycle();
            chk("t41_hold", 32'(res_sum), 32'h1);
        end
        res_ready = 1'b1;
        #1 chk("t41_go", 32'(req_ready), 32'b0100);
        cycle();

        req_valid = 4'b1000;
        set_beat(3, 20'hABCDE, 20'h54321, 1'b1, 1'b0);
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("t42_rv", 32'(res_valid), 32'h0);
        req_valid = 4'hF;
        req_last  = 4'hF;
        #1 chk("t42_g0", 32'(req_ready), 32'b0001);
        cycle();

        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom % 64) != 0;
            res_ready = ($urandom % 4) != 0;
            req_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                case ($urandom % 4)
                    0:       set_beat(i, 20'hFFFFF, 20'($urandom % 3),
                                      1'($urandom), 1'($urandom % 3 != 0));
                    default: set_beat(i, 20'($urandom), 20'($urandom),
                                      1'($urandom), 1'($urandom % 3 != 0));
                endcase
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
